// File: rtl/multi_one_pulser.sv
// Per-channel push-button synchroniser, debouncer and one-shot/auto-repeat pulser.
// Press pulse and level rise DB_CYCLES+1 edges after clkPB is first sampled high; no backpressure.
module multi_one_pulser #(
  parameter int NUM_CH      = 4,
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int RPT_CYCLES  = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] clkPB,
  input  logic [NUM_CH-1:0] rptEn,
  output logic [NUM_CH-1:0] clkEn,
  output logic [NUM_CH-1:0] level
);

  localparam int DBW    = $clog2(DB_CYCLES + 1);
  localparam int HC_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int HCW    = $clog2(HC_MAX);

  localparam logic [DBW-1:0] DB_TC   = DBW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_TC = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0] RPT_TC  = HCW'(RPT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, RELEASE} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic [DBW-1:0] dbc_q, dbc_d;
    logic           level_q, level_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic           pulse_q, pulse_d;
    state_t         state_q, state_d;
    logic           rise, fall;

    always_comb begin
      s1_d    = clkPB[i];
      s2_d    = s1_q;
      level_d = level_q;
      dbc_d   = dbc_q;
      if (s2_q == level_q) begin
        dbc_d = '0;
      end else if (dbc_q == DB_TC) begin
        level_d = ~level_q;
        dbc_d   = '0;
      end else begin
        dbc_d = dbc_q + DBW'(1);
      end
    end

    // Edge events are taken from the debouncer's next state so the press
    // pulse registers on the same edge as the level rise.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        dbc_q   <= '0;
        level_q <= 1'b0;
        hc_q    <= '0;
        pulse_q <= 1'b0;
        state_q <= IDLE;
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        dbc_q   <= dbc_d;
        level_q <= level_d;
        hc_q    <= hc_d;
        pulse_q <= pulse_d;
        state_q <= state_d;
      end
    end

    // Release beats repeat-disable, which beats a due repeat pulse.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (rise) state_d = rptEn[i] ? HOLD : RELEASE;
        HOLD: begin
          if (fall)                 state_d = IDLE;
          else if (!rptEn[i])       state_d = RELEASE;
          else if (hc_q == HOLD_TC) state_d = REPEAT;
        end
        REPEAT: begin
          if (fall)           state_d = IDLE;
          else if (!rptEn[i]) state_d = RELEASE;
        end
        RELEASE: if (fall) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      pulse_d = 1'b0;
      hc_d    = hc_q;
      case (state_q)
        IDLE: begin
          if (rise) begin
            pulse_d = 1'b1;
            hc_d    = '0;
          end
        end
        HOLD: begin
          if (!fall && rptEn[i]) begin
            if (hc_q == HOLD_TC) begin
              pulse_d = 1'b1;
              hc_d    = '0;
            end else begin
              hc_d = hc_q + HCW'(1);
            end
          end
        end
        REPEAT: begin
          if (!fall && rptEn[i]) begin
            if (hc_q == RPT_TC) begin
              pulse_d = 1'b1;
              hc_d    = '0;
            end else begin
              hc_d = hc_q + HCW'(1);
            end
          end
        end
        default: begin
          pulse_d = 1'b0;
          hc_d    = hc_q;
        end
      endcase
    end

    assign clkEn[i] = pulse_q;
    assign level[i] = level_q;
  end

endmodule

// File: tb/tb_multi_one_pulser.sv
// Directed bench for multi_one_pulser; expected pulse cycles are queued per channel
// at stimulus time and matched against clkEn by a negedge monitor.
module tb_multi_one_pulser;
  localparam int NCH  = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 4;
  localparam int LAT  = DB + 2;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic [NCH-1:0] clkPB = '0;
  logic [NCH-1:0] rptEn = '0;
  logic [NCH-1:0] clkEn;
  logic [NCH-1:0] level;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int exp_q [NCH][$];

  multi_one_pulser #(
    .NUM_CH(NCH), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)
  ) dut (
    .clk(clk), .rst(rst), .clkPB(clkPB), .rptEn(rptEn), .clkEn(clkEn), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must be expected and every expected pulse must appear on its cycle.
  bit due;
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      due = (exp_q[c].size() > 0) && (exp_q[c][0] == cyc);
      if (due || clkEn[c]) begin
        checks++;
        assert (clkEn[c] === due) else begin
          errors++;
          $error("FAIL pulse_ch%0d cycle %0d observed clkEn=%0b expected %0b", c, cyc, clkEn[c], due);
        end
        if (due) void'(exp_q[c].pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int ch, output int p);
    p = cyc + LAT;
    clkPB[ch] = 1'b1;
    exp_q[ch].push_back(p);
  endtask

  task automatic release_btn(input int ch, input string tag);
    int n;
    n = cyc;
    clkPB[ch] = 1'b0;
    wait_cyc(n + LAT - 1);
    chk({tag, "_lvl_held"}, 32'(level[ch]), 32'd1);
    wait_cyc(n + LAT);
    chk({tag, "_lvl_fell"}, 32'(level[ch]), 32'd0);
  endtask

  initial begin
    int p, p3, n;
    wait_cyc(3);
    chk("rst_clken", 32'(clkEn), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst = 1'b0;

    // Basic press, no repeat
    wait_cyc(cyc + 2);
    press(0, p);
    wait_cyc(p - 1);
    chk("t1_level_pre", 32'(level), 32'd0);
    wait_cyc(p);
    chk("t1_level", 32'(level), 32'b0001);
    chk("t1_clken", 32'(clkEn), 32'b0001);
    wait_cyc(p + 1);
    chk("t1_clken_fall", 32'(clkEn), 32'd0);
    wait_cyc(p + 5);
    release_btn(0, "t1");

    // Bounce rejection: 3-cycle high runs never reach DB stable samples
    for (int k = 0; k < 40; k++) begin
      clkPB[1] = ((k % 5) < 3);
      wait_cyc(cyc + 1);
    end
    clkPB[1] = 1'b0;
    wait_cyc(cyc + 3);
    chk("t2_bounce_level", 32'(level[1]), 32'd0);
    press(1, p);
    wait_cyc(p);
    chk("t2_steady_level", 32'(level[1]), 32'd1);
    wait_cyc(p + 4);
    release_btn(1, "t2");

    // Auto-repeat held through several repeats, then released
    rptEn[2] = 1'b1;
    wait_cyc(cyc + 2);
    press(2, p);
    for (int k = 10; k <= 34; k += 4) exp_q[2].push_back(p + k);
    wait_cyc(p + 30);
    release_btn(2, "t3");
    wait_cyc(cyc + 8);

    // Release lands exactly on a due repeat edge: release wins
    press(2, p);
    exp_q[2].push_back(p + HOLD);
    exp_q[2].push_back(p + HOLD + RPT);
    wait_cyc(p + 12);
    release_btn(2, "t4_collide");
    wait_cyc(cyc + 4);

    // Repeat disable mid-REPEAT; re-enabling in RELEASE has no effect
    press(2, p);
    exp_q[2].push_back(p + HOLD);
    wait_cyc(p + 12);
    rptEn[2] = 1'b0;
    wait_cyc(p + 16);
    rptEn[2] = 1'b1;
    wait_cyc(p + 30);
    release_btn(2, "t5_disable");
    wait_cyc(cyc + 4);

    // Asynchronous reset mid-REPEAT with the button held
    press(2, p);
    exp_q[2].push_back(p + HOLD);
    wait_cyc(p + 12);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_clken", 32'(clkEn), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    exp_q[2].delete();
    rptEn[2] = 1'b0;
    @(posedge clk);
    #1;
    n = cyc;
    rst = 1'b0;
    exp_q[2].push_back(n + LAT);
    wait_cyc(n + LAT - 1);
    chk("t6_level_pre", 32'(level[2]), 32'd0);
    wait_cyc(n + LAT);
    chk("t6_clken", 32'(clkEn), 32'b0100);
    wait_cyc(cyc + 20);
    release_btn(2, "t6");

    // Simultaneous presses on channels 0 and 3
    wait_cyc(cyc + 2);
    press(0, p);
    press(3, p3);
    wait_cyc(p);
    chk("t7_clken", 32'(clkEn), 32'b1001);
    chk("t7_level", 32'(level), 32'b1001);
    wait_cyc(p + 1);
    chk("t7_clken_fall", 32'(clkEn), 32'd0);
    wait_cyc(p + 5);
    n = cyc;
    clkPB[0] = 1'b0;
    clkPB[3] = 1'b0;
    wait_cyc(n + LAT);
    chk("t7_level_fell", 32'(level), 32'd0);

    wait_cyc(cyc + 10);
    for (int c = 0; c < NCH; c++) chk($sformatf("q_empty_ch%0d", c), 32'(exp_q[c].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d observed no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
